// File: rtl/fft_frame_feeder.sv
// Frames a stream of signed audio samples into fixed-length AXI-Stream beats for the FFT core,
// with an input FIFO, tlast marking, backpressure handling and zero-padding of the final frame.
module fft_frame_feeder #(
  parameter int SAMPLE_W   = 8,
  parameter int FRAME_LEN  = 2048,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                sample_valid_in,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                finish_in,
  output logic [31:0]         m_tdata_out,
  output logic                m_tvalid_out,
  input  logic                m_tready_in,
  output logic                m_tlast_out,
  output logic [CNT_W-1:0]    frame_count_out,
  output logic                overflow_out,
  output logic                busy_out,
  output logic                done_out
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(FRAME_LEN - 1);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    PAD    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state_reg;

  // Input FIFO storage and pointers
  logic [SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [PTR_W:0]      count_reg;

  // Output beat register and frame bookkeeping
  logic [31:0]      tdata_reg;
  logic             tvalid_reg;
  logic             tlast_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [CNT_W-1:0] frame_count_reg;
  logic             overflow_reg;
  logic             flush_reg;
  logic             done_reg;

  logic                fifo_empty;
  logic                fifo_full;
  logic                xfer;
  logic                load_slot;
  logic                pop;
  logic                push;
  logic                drop;
  logic [IDX_W-1:0]    idx_next;
  logic                load_is_last;
  logic [SAMPLE_W-1:0] rd_data;
  logic [15:0]         rd_real;

  assign fifo_empty   = (count_reg == '0);
  assign fifo_full    = (count_reg == FULL_CNT);
  assign xfer         = tvalid_reg && m_tready_in;
  assign load_slot    = !tvalid_reg || xfer;
  assign pop          = (state_reg == STREAM) && !fifo_empty && load_slot;
  // Samples arriving while padding are discarded without flagging overflow.
  assign push         = sample_valid_in && (state_reg != PAD) && (!fifo_full || pop);
  assign drop         = sample_valid_in && (state_reg != PAD) && fifo_full && !pop;
  // Index of the beat that would be loaded this cycle.
  assign idx_next     = xfer ? idx_reg + IDX_W'(1) : idx_reg;
  assign load_is_last = (idx_next == LAST_IDX);
  assign rd_data      = mem[rd_ptr_reg];

  generate
    if (SAMPLE_W == 16) begin : g_real_full
      assign rd_real = rd_data;
    end else begin : g_real_pad
      assign rd_real = {rd_data, {(16 - SAMPLE_W){1'b0}}};
    end
  endgenerate

  // FIFO storage is left unreset so it maps onto RAM.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr_reg] <= sample_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_reg       <= IDLE;
      tdata_reg       <= '0;
      tvalid_reg      <= 1'b0;
      tlast_reg       <= 1'b0;
      idx_reg         <= '0;
      frame_count_reg <= '0;
      overflow_reg    <= 1'b0;
      flush_reg       <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (drop) begin
        overflow_reg <= 1'b1;
      end
      if (xfer) begin
        idx_reg <= idx_reg + IDX_W'(1);
        if (tlast_reg) begin
          frame_count_reg <= frame_count_reg + CNT_W'(1);
        end
      end

      case (state_reg)
        IDLE: begin
          if (push || !fifo_empty) begin
            state_reg <= STREAM;
            flush_reg <= flush_reg || finish_in;
          end else if (finish_in && idx_reg == '0) begin
            state_reg <= DONE;
          end
        end

        STREAM: begin
          if (finish_in) begin
            flush_reg <= 1'b1;
          end
          if (load_slot) begin
            if (!fifo_empty) begin
              tdata_reg  <= {rd_real, 16'h0000};
              tvalid_reg <= 1'b1;
              tlast_reg  <= load_is_last;
            end else begin
              tvalid_reg <= 1'b0;
              tlast_reg  <= 1'b0;
            end
          end
          // Everything buffered has left the block; finish the frame or stop.
          if (flush_reg && fifo_empty && !tvalid_reg && !sample_valid_in) begin
            state_reg <= (idx_reg == '0) ? DONE : PAD;
          end
        end

        PAD: begin
          if (load_slot) begin
            if (xfer && tlast_reg) begin
              tvalid_reg <= 1'b0;
              tlast_reg  <= 1'b0;
              state_reg  <= DONE;
            end else begin
              tdata_reg  <= '0;
              tvalid_reg <= 1'b1;
              tlast_reg  <= load_is_last;
            end
          end
        end

        DONE: begin
          done_reg  <= 1'b1;
          flush_reg <= 1'b0;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign m_tdata_out     = tdata_reg;
  assign m_tvalid_out    = tvalid_reg;
  assign m_tlast_out     = tlast_reg;
  assign frame_count_out = frame_count_reg;
  assign overflow_out    = overflow_reg;
  assign busy_out        = (state_reg == STREAM) || (state_reg == PAD);
  assign done_out        = done_reg;

endmodule
